mii_phy_rx_gen: RTL and testbench

MII_PHY_RX_GEN -- requirements
Module: mii_phy_rx_gen

---
 rtl/eth_mii_pkg.sv | 28 ++
 rtl/lfsr.sv | 33 +++
 rtl/mii_phy_rx_gen.sv | 202 ++++++++++++++++++++
 tb/tb_mii_phy_rx_gen.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_mii_pkg.sv
// Shared types and constants for the MII receive-side frame generator.
package eth_mii_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_FCS,
    ST_ABORT,
    ST_DRAIN,
    ST_IFG
  } rx_state_e;

  localparam logic [3:0]  NIB_PREAMBLE = 4'h5;
  localparam logic [3:0]  NIB_SFD      = 4'hD;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

  // The IDLE decision cycle is part of the gap, so the IFG state holds one cycle less.
  function automatic logic [8:0] ifg_load(input logic [7:0] ifg);
    logic [7:0] bytes;
    bytes    = (ifg == 8'd0) ? 8'd1 : ifg;
    ifg_load = {bytes, 1'b0} - 9'd1;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Reflected Galois LFSR / CRC engine, DATA_W bits per advance, LSB of data first.
// Registered state; init takes priority over advance.
module lfsr #(
  parameter int               WIDTH  = 32,
  parameter int               DATA_W = 8,
  parameter logic [WIDTH-1:0] POLY   = 32'hEDB88320,
  parameter logic [WIDTH-1:0] INIT   = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              advance,
  input  logic [DATA_W-1:0] data,
  output logic [WIDTH-1:0]  lfsr_q
);

  logic [WIDTH-1:0] lfsr_nxt;

  always_comb begin
    lfsr_nxt = lfsr_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (lfsr_nxt[0] ^ data[i]) lfsr_nxt = (lfsr_nxt >> 1) ^ POLY;
      else                       lfsr_nxt = lfsr_nxt >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lfsr_q <= INIT;
    else if (init)    lfsr_q <= INIT;
    else if (advance) lfsr_q <= lfsr_nxt;
  end

endmodule

// File: rtl/mii_phy_rx_gen.sv
// Turns AXI-stream bytes into PHY-side MII receive nibbles (preamble, SFD, data, FCS, IFG);
// outputs registered one cycle after the state decision; tready only when a byte is needed.
module mii_phy_rx_gen
  import eth_mii_pkg::*;
#(
  parameter bit ENABLE_FCS       = 1'b1,
  parameter int PREAMBLE_NIBBLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [3:0] mii_rxd,
  output logic       mii_rx_dv,
  output logic       mii_rx_er,
  input  logic [7:0] cfg_ifg,
  input  logic       cfg_enable,
  output logic       status_frame_done,
  output logic       status_underflow
);

  rx_state_e   state_q, state_d;
  logic [3:0]  nib_cnt_q, nib_cnt_d;
  logic [8:0]  ifg_cnt_q, ifg_cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic        user_q, user_d;

  logic [31:0] crc;
  logic [31:0] fcs_shift;
  logic        crc_advance;

  logic [3:0]  rxd_d;
  logic        dv_d, er_d, done_d, unf_d;

  assign s_axis_tready = (state_q == ST_SFD) ||
                         (state_q == ST_DATA_HI && !last_q) ||
                         (state_q == ST_DRAIN);

  // Only bytes that go on the wire feed the CRC; drained bytes do not.
  assign crc_advance = s_axis_tvalid && s_axis_tready && (state_q != ST_DRAIN);

  lfsr #(
    .WIDTH  (32),
    .DATA_W (8),
    .POLY   (CRC32_POLY),
    .INIT   (CRC32_INIT)
  ) u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (state_q == ST_IDLE),
    .advance (crc_advance),
    .data    (s_axis_tdata),
    .lfsr_q  (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      nib_cnt_q <= '0;
      ifg_cnt_q <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      user_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nib_cnt_q <= nib_cnt_d;
      ifg_cnt_q <= ifg_cnt_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      user_q    <= user_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nib_cnt_d = nib_cnt_q;
    ifg_cnt_d = ifg_cnt_q;
    byte_d    = byte_q;
    last_d    = last_q;
    user_d    = user_q;

    case (state_q)
      ST_IDLE: begin
        if (ifg_cnt_q != 9'd0) begin
          ifg_cnt_d = ifg_cnt_q - 9'd1;
        end else if (s_axis_tvalid && cfg_enable) begin
          state_d   = ST_PREAMBLE;
          nib_cnt_d = '0;
        end
      end
      ST_PREAMBLE: begin
        if (nib_cnt_q == 4'(PREAMBLE_NIBBLES - 1)) state_d = ST_SFD;
        else                                       nib_cnt_d = nib_cnt_q + 4'd1;
      end
      ST_DATA_LO: state_d = ST_DATA_HI;
      ST_SFD, ST_DATA_HI: begin
        if (state_q == ST_DATA_HI && last_q) begin
          if (ENABLE_FCS) begin
            state_d   = ST_FCS;
            nib_cnt_d = '0;
          end else begin
            state_d   = ST_IFG;
            ifg_cnt_d = ifg_load(cfg_ifg);
          end
        end else if (s_axis_tvalid) begin
          state_d = ST_DATA_LO;
          byte_d  = s_axis_tdata;
          last_d  = s_axis_tlast;
          user_d  = s_axis_tuser;
        end else begin
          state_d = ST_ABORT;
        end
      end
      ST_FCS: begin
        if (nib_cnt_q == 4'd7) begin
          state_d   = ST_IFG;
          ifg_cnt_d = ifg_load(cfg_ifg);
        end else begin
          nib_cnt_d = nib_cnt_q + 4'd1;
        end
      end
      ST_ABORT: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d   = ST_IFG;
          ifg_cnt_d = ifg_load(cfg_ifg);
        end
      end
      ST_IFG: begin
        if (ifg_cnt_q <= 9'd1) begin
          state_d   = ST_IDLE;
          ifg_cnt_d = '0;
        end else begin
          ifg_cnt_d = ifg_cnt_q - 9'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    rxd_d     = 4'h0;
    dv_d      = 1'b0;
    er_d      = 1'b0;
    done_d    = 1'b0;
    unf_d     = 1'b0;
    fcs_shift = ~crc >> {nib_cnt_d[2:0], 2'b00};

    case (state_d)
      ST_PREAMBLE: begin
        dv_d  = 1'b1;
        rxd_d = NIB_PREAMBLE;
      end
      ST_SFD: begin
        dv_d  = 1'b1;
        rxd_d = NIB_SFD;
      end
      ST_DATA_LO: begin
        dv_d  = 1'b1;
        rxd_d = byte_d[3:0];
        er_d  = last_d && user_d;
      end
      ST_DATA_HI: begin
        dv_d   = 1'b1;
        rxd_d  = byte_d[7:4];
        er_d   = last_d && user_d;
        done_d = !ENABLE_FCS && last_d;
      end
      ST_FCS: begin
        dv_d   = 1'b1;
        rxd_d  = fcs_shift[3:0];
        done_d = (nib_cnt_d == 4'd7);
      end
      ST_ABORT: begin
        dv_d  = 1'b1;
        er_d  = 1'b1;
        unf_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mii_rxd           <= 4'h0;
      mii_rx_dv         <= 1'b0;
      mii_rx_er         <= 1'b0;
      status_frame_done <= 1'b0;
      status_underflow  <= 1'b0;
    end else begin
      mii_rxd           <= rxd_d;
      mii_rx_dv         <= dv_d;
      mii_rx_er         <= er_d;
      status_frame_done <= done_d;
      status_underflow  <= unf_d;
    end
  end

endmodule

// File: tb/tb_mii_phy_rx_gen.sv
// Self-checking bench for mii_phy_rx_gen against a frame-level nibble-stream model.
module tb_mii_phy_rx_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic [3:0] mii_rxd;
  logic       mii_rx_dv;
  logic       mii_rx_er;
  logic [7:0] cfg_ifg = 8'd12;
  logic       cfg_enable = 1'b1;
  logic       status_frame_done;
  logic       status_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mii_phy_rx_gen dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tuser      (s_axis_tuser),
    .mii_rxd           (mii_rxd),
    .mii_rx_dv         (mii_rx_dv),
    .mii_rx_er         (mii_rx_er),
    .cfg_ifg           (cfg_ifg),
    .cfg_enable        (cfg_enable),
    .status_frame_done (status_frame_done),
    .status_underflow  (status_underflow)
  );

  // ---------------- monitor: collects frames as seen on the MII ----------------
  logic [3:0] cur_nib[$];
  logic       cur_er[$];
  logic [3:0] fr_nib[$];
  logic       fr_er[$];
  int         gap_q[$];
  int frames_seen = 0, done_total = 0, unf_total = 0;
  int done_pos = -1, fr_done_pos = -1, gap_cnt = -1;
  logic prev_dv = 1'b0;

  always @(negedge clk) begin
    if (mii_rx_dv) begin
      if (!prev_dv && gap_cnt >= 0) gap_q.push_back(gap_cnt);
      cur_nib.push_back(mii_rxd);
      cur_er.push_back(mii_rx_er);
    end else if (prev_dv) begin
      fr_nib = cur_nib;
      fr_er  = cur_er;
      fr_done_pos = done_pos;
      cur_nib = {};
      cur_er  = {};
      done_pos = -1;
      frames_seen++;
      gap_cnt = 1;
    end else if (gap_cnt >= 0) begin
      gap_cnt++;
    end
    if (status_frame_done) begin
      done_total++;
      done_pos = mii_rx_dv ? cur_nib.size() : -2;
    end
    if (status_underflow) unf_total++;
    prev_dv = mii_rx_dv;
  end

  // ---------------- reference model ----------------
  logic [7:0] pl[$];
  logic [3:0] exp_nib[$];
  logic       exp_er[$];

  function automatic logic [31:0] crc32_ref();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pl[k]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ pl[k][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                 c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic build_expected(input bit user, input int abort_at);
    logic [7:0]  b;
    logic [31:0] f;
    int n;
    exp_nib = {};
    exp_er  = {};
    repeat (15) begin exp_nib.push_back(4'h5); exp_er.push_back(1'b0); end
    exp_nib.push_back(4'hD); exp_er.push_back(1'b0);
    n = (abort_at >= 0) ? abort_at : pl.size();
    for (int k = 0; k < n; k++) begin
      b = pl[k];
      exp_nib.push_back(b[3:0]); exp_er.push_back(user && (k == pl.size() - 1));
      exp_nib.push_back(b[7:4]); exp_er.push_back(user && (k == pl.size() - 1));
    end
    if (abort_at >= 0) begin
      exp_nib.push_back(4'h0); exp_er.push_back(1'b1);
    end else begin
      f = ~crc32_ref();
      for (int i = 0; i < 8; i++) begin
        exp_nib.push_back(4'(f >> (4 * i)));
        exp_er.push_back(1'b0);
      end
    end
  endtask

  task automatic random_payload(input int len);
    pl = {};
    for (int k = 0; k < len; k++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic compare_frame(input string name);
    int bad;
    bad = -1;
    n_checks++;
    if (fr_nib.size() != exp_nib.size()) begin
      n_fail++;
      $display("FAIL %s_len: got %0d nibbles, expected %0d", name, fr_nib.size(), exp_nib.size());
    end
    n_checks++;
    for (int k = 0; k < fr_nib.size() && k < exp_nib.size(); k++)
      if (bad < 0 && (fr_nib[k] !== exp_nib[k] || fr_er[k] !== exp_er[k])) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_data: nibble %0d got rxd=%h er=%b, expected rxd=%h er=%b",
               name, bad, fr_nib[bad], fr_er[bad], exp_nib[bad], exp_er[bad]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_frame(input bit user, input int stall_idx, output bit ok);
    int i, guard;
    bit stalled;
    i = 0; guard = 0; stalled = 0; ok = 1;
    while (i < pl.size()) begin
      if (i == stall_idx && !stalled) begin
        stalled = 1;
        s_axis_tvalid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pl[i];
      s_axis_tlast  = (i == pl.size() - 1);
      s_axis_tuser  = user && (i == pl.size() - 1);
      @(negedge clk);
      if (!rst_n) begin ok = 0; break; end
      if (s_axis_tready) i++;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 5000) begin ok = 0; break; end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic check_driven(input string name, input bit ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_accept: not all bytes accepted, got ok=%b expected 1", name, ok);
    end
  endtask

  task automatic wait_frames(input string name, input int target);
    int c;
    c = 0;
    while (frames_seen < target && c < 3000) begin @(posedge clk); c++; end
    #1;
    n_checks++;
    if (frames_seen < target) begin
      n_fail++;
      $display("FAIL %s_timeout: frames seen %0d, expected %0d", name, frames_seen, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mii_rx_dv, mii_rx_er, mii_rxd, status_frame_done, status_underflow, s_axis_tready} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {mii_rx_dv, mii_rx_er, mii_rxd, status_frame_done, status_underflow, s_axis_tready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({mii_rx_dv, mii_rx_er, mii_rxd, s_axis_tready} !== 7'd0) begin
      n_fail++;
      $display("FAIL release_outputs: got %b, expected all zero", {mii_rx_dv, mii_rx_er, mii_rxd, s_axis_tready});
    end
    @(posedge clk);
    #1;
  endtask

  // dv must be low on the first sample after tvalid appears and high on the next.
  task automatic check_start_latency(input string name);
    @(negedge clk);
    n_checks++;
    if (mii_rx_dv !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start0: dv got %b expected 0", name, mii_rx_dv);
    end
    @(negedge clk);
    n_checks++;
    if (mii_rx_dv !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start1: dv got %b expected 1", name, mii_rx_dv);
    end
  endtask

  task automatic test_counting_frame();
    int base, d0, u0;
    bit ok;
    pl = {};
    for (int k = 0; k < 60; k++) pl.push_back(8'(k));
    base = frames_seen; d0 = done_total; u0 = unf_total;
    fork
      drive_frame(1'b0, -1, ok);
      check_start_latency("count");
    join
    check_driven("count", ok);
    wait_frames("count", base + 1);
    build_expected(1'b0, -1);
    compare_frame("count");
    n_checks++;
    if (fr_nib.size() != 144) begin
      n_fail++;
      $display("FAIL count_dv_len: dv high %0d cycles, expected 144", fr_nib.size());
    end
    n_checks++;
    if (done_total - d0 != 1 || fr_done_pos != 144) begin
      n_fail++;
      $display("FAIL count_done: pulses %0d at nibble %0d, expected 1 at 144", done_total - d0, fr_done_pos);
    end
    n_checks++;
    if (unf_total != u0) begin
      n_fail++;
      $display("FAIL count_underflow: pulses %0d, expected 0", unf_total - u0);
    end
  endtask

  task automatic test_check_string();
    string s;
    logic [3:0] kv[8];
    logic [3:0] got;
    int base, bad;
    bit ok;
    s = "123456789";
    kv = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    pl = {};
    for (int k = 0; k < s.len(); k++) pl.push_back(s[k]);
    base = frames_seen;
    drive_frame(1'b0, -1, ok);
    check_driven("crc_str", ok);
    wait_frames("crc_str", base + 1);
    build_expected(1'b0, -1);
    compare_frame("crc_str");
    bad = -1;
    got = 4'h0;
    n_checks++;
    for (int i = 0; i < 8; i++) begin
      if (fr_nib.size() >= 8 && bad < 0 && fr_nib[fr_nib.size() - 8 + i] !== kv[i]) begin
        bad = i;
        got = fr_nib[fr_nib.size() - 8 + i];
      end
    end
    if (fr_nib.size() < 8 || bad >= 0) begin
      n_fail++;
      $display("FAIL crc_str_fcs: fcs nibble %0d got %h expected %h", bad, got, kv[(bad < 0) ? 0 : bad]);
    end
  endtask

  task automatic test_random_frames();
    int base, d0;
    bit ok, user;
    for (int r = 0; r < 6; r++) begin
      random_payload($urandom_range(1, 40));
      user = 1'($urandom_range(0, 1));
      cfg_ifg = 8'($urandom_range(0, 5));
      base = frames_seen; d0 = done_total;
      drive_frame(user, -1, ok);
      check_driven("rand", ok);
      wait_frames("rand", base + 1);
      build_expected(user, -1);
      compare_frame("rand");
      n_checks++;
      if (done_total - d0 != 1 || fr_done_pos != exp_nib.size()) begin
        n_fail++;
        $display("FAIL rand_done: pulses %0d at nibble %0d, expected 1 at %0d",
                 done_total - d0, fr_done_pos, exp_nib.size());
      end
    end
    cfg_ifg = 8'd12;
  endtask

  task automatic test_underflow();
    int base, d0, u0;
    bit ok;
    random_payload(20);
    base = frames_seen; d0 = done_total; u0 = unf_total;
    drive_frame(1'b0, 4, ok);
    check_driven("underflow", ok);
    wait_frames("underflow", base + 1);
    repeat (40) @(posedge clk);
    #1;
    build_expected(1'b0, 4);
    compare_frame("underflow");
    n_checks++;
    if (unf_total - u0 != 1) begin
      n_fail++;
      $display("FAIL underflow_pulse: pulses %0d, expected 1", unf_total - u0);
    end
    n_checks++;
    if (done_total != d0) begin
      n_fail++;
      $display("FAIL underflow_done: pulses %0d, expected 0", done_total - d0);
    end
    n_checks++;
    if (frames_seen != base + 1) begin
      n_fail++;
      $display("FAIL underflow_frames: frames %0d, expected %0d", frames_seen, base + 1);
    end
  endtask

  task automatic test_tuser();
    int base, ers;
    bit ok;
    random_payload(10);
    base = frames_seen;
    drive_frame(1'b1, -1, ok);
    check_driven("tuser", ok);
    wait_frames("tuser", base + 1);
    build_expected(1'b1, -1);
    compare_frame("tuser");
    ers = 0;
    foreach (fr_er[k]) ers += int'(fr_er[k]);
    n_checks++;
    if (ers != 2) begin
      n_fail++;
      $display("FAIL tuser_er_count: er nibbles %0d, expected 2", ers);
    end
  endtask

  task automatic test_back_to_back();
    int base, gap, want, ifgs[3];
    bit ok;
    ifgs[0] = 12;
    ifgs[1] = 0;
    ifgs[2] = $urandom_range(1, 20);
    for (int t = 0; t < 3; t++) begin
      cfg_ifg = 8'(ifgs[t]);
      want = 2 * ((ifgs[t] == 0) ? 1 : ifgs[t]);
      random_payload(8);
      base = frames_seen;
      drive_frame(1'b0, -1, ok);
      check_driven("b2b_a", ok);
      random_payload($urandom_range(1, 12));
      drive_frame(1'b0, -1, ok);
      check_driven("b2b_b", ok);
      wait_frames("b2b", base + 2);
      build_expected(1'b0, -1);
      compare_frame("b2b_second");
      gap = (gap_q.size() > 0) ? gap_q[$] : -1;
      n_checks++;
      if (gap != want) begin
        n_fail++;
        $display("FAIL b2b_gap: ifg %0d gave %0d idle cycles, expected %0d", ifgs[t], gap, want);
      end
    end
    cfg_ifg = 8'd12;
  endtask

  task automatic test_cfg_enable();
    int base, seen, c;
    bit ok;
    random_payload(16);
    base = frames_seen;
    cfg_enable = 1'b0;
    seen = 0;
    fork
      drive_frame(1'b0, -1, ok);
      begin
        repeat (30) begin @(negedge clk); seen += int'(mii_rx_dv); end
        n_checks++;
        if (seen != 0) begin
          n_fail++;
          $display("FAIL enable_gate: dv high %0d cycles while disabled, expected 0", seen);
        end
        @(posedge clk);
        #1;
        cfg_enable = 1'b1;
        c = 0;
        while (!mii_rx_dv && c < 50) begin @(negedge clk); c++; end
        cfg_enable = 1'b0;
      end
    join
    check_driven("enable", ok);
    wait_frames("enable", base + 1);
    cfg_enable = 1'b1;
    build_expected(1'b0, -1);
    compare_frame("enable_midframe");
  endtask

  task automatic test_reset_midframe();
    int base, c;
    bit ok;
    logic [7:0] b1;
    random_payload(12);
    b1 = pl[1];
    fork
      drive_frame(1'b0, -1, ok);
      begin
        c = 0;
        while (!mii_rx_dv && c < 100) begin @(negedge clk); c++; end
        repeat (18) @(negedge clk);
        n_checks++;
        if (mii_rxd !== b1[3:0] || mii_rx_dv !== 1'b1) begin
          n_fail++;
          $display("FAIL rst_mid_pos: rxd %h dv %b, expected rxd %h dv 1", mii_rxd, mii_rx_dv, b1[3:0]);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mii_rx_dv, mii_rx_er, mii_rxd} !== 6'd0) begin
          n_fail++;
          $display("FAIL rst_mid_async: got dv/er/rxd %b, expected 0", {mii_rx_dv, mii_rx_er, mii_rxd});
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    random_payload(24);
    base = frames_seen;
    fork
      drive_frame(1'b0, -1, ok);
      check_start_latency("rst_fresh");
    join
    check_driven("rst_fresh", ok);
    wait_frames("rst_fresh", base + 1);
    build_expected(1'b0, -1);
    compare_frame("rst_fresh");
  endtask

  initial begin
    test_reset();
    test_counting_frame();
    test_check_string();
    test_random_frames();
    test_underflow();
    test_tuser();
    test_back_to_back();
    test_cfg_enable();
    test_reset_midframe();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
